// File: rtl/fan_ctrl_defs.sv
// Shared fan-control encodings: speed codes and FSM state encodings used by
// fan_speed_controller and fan_pwm_driver.
package fan_ctrl_defs;

  typedef enum logic [1:0] {
    FAN_OFF  = 2'd0,
    FAN_LOW  = 2'd1,
    FAN_MED  = 2'd2,
    FAN_HIGH = 2'd3
  } fan_speed_e;

  // 3-bit to match fan_speed_controller's current_state width.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_RAMP_DOWN = 3'd2,
    ST_HOLD      = 3'd3,
    ST_STALL     = 3'd4
  } fan_state_e;

endpackage

// File: rtl/tach_sync_edge.sv
// Brings the asynchronous fan tach into the clk domain and emits a one-cycle
// pulse for every rising edge.
module tach_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic tach_i,
  output logic edge_o
);

  logic sync1_q, sync2_q, prev_q;

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= tach_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/fan_pwm_driver.sv
// Soft-start/stop fan PWM driver: slews duty toward the requested speed level,
// generates a period-aligned PWM and shuts down on a tach stall.
module fan_pwm_driver
  import fan_ctrl_defs::*;
#(
  parameter int PWM_BITS      = 8,
  parameter int RAMP_DIV      = 16,
  parameter int RAMP_STEP     = 5,
  parameter int DUTY_LOW      = 85,
  parameter int DUTY_MED      = 170,
  parameter int DUTY_HIGH     = 255,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          fan_speed,
  input  logic                speed_set,
  input  logic                tach_in,
  input  logic                fault_clear,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty,
  output logic                ramp_busy,
  output logic                stall_fault
);

  localparam int DIV_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [PWM_BITS-1:0] STEP    = PWM_BITS'(RAMP_STEP);
  localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'((2 ** PWM_BITS) - 2);
  localparam logic [DIV_W-1:0]    DIV_MAX = DIV_W'(RAMP_DIV - 1);
  localparam logic [STALL_W-1:0]  STALL_LIM = STALL_W'(STALL_TIMEOUT);

  fan_state_e          state_q, state_d;
  logic [PWM_BITS-1:0] target_q, target_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] req_duty, duty_ramp;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_act_q, duty_act_d;
  logic                pwm_q, pwm_d;
  logic                ramp_tick, tach_edge, pwm_kill;

  tach_sync_edge u_tach (
    .clk    (clk),
    .rst_n  (reset_n),
    .tach_i (tach_in),
    .edge_o (tach_edge)
  );

  assign ramp_tick = (div_q == DIV_MAX);
  assign div_d     = ramp_tick ? '0 : div_q + 1'b1;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    req_duty = '0;
    case (fan_speed_e'(fan_speed))
      FAN_LOW:  req_duty = PWM_BITS'(DUTY_LOW);
      FAN_MED:  req_duty = PWM_BITS'(DUTY_MED);
      FAN_HIGH: req_duty = PWM_BITS'(DUTY_HIGH);
      default:  req_duty = '0;
    endcase
  end

  // One step toward target per tick, clamped at target so it can never wrap.
  always_comb begin
    duty_ramp = duty_q;
    if (ramp_tick) begin
      if (target_q > duty_q)
        duty_ramp = ((target_q - duty_q) > STEP) ? duty_q + STEP : target_q;
      else if (target_q < duty_q)
        duty_ramp = ((duty_q - target_q) > STEP) ? duty_q - STEP : target_q;
    end
  end

  always_comb begin
    target_d = target_q;
    if (speed_set && state_q != ST_STALL) target_d = req_duty;

    state_d = state_q;
    case (state_q)
      ST_HOLD: begin
        // A retarget is seen a cycle early so it beats a same-cycle timeout.
        if (target_d > duty_q)       state_d = ST_RAMP_UP;
        else if (target_d < duty_q)  state_d = ST_RAMP_DOWN;
        else if (stall_cnt_q == STALL_LIM && !tach_edge) state_d = ST_STALL;
      end
      ST_STALL: begin
        if (fault_clear) state_d = ST_IDLE;
      end
      default: begin
        if (duty_ramp == target_q)
          state_d = (target_q == '0) ? ST_IDLE : ST_HOLD;
        else
          state_d = (target_q > duty_ramp) ? ST_RAMP_UP : ST_RAMP_DOWN;
      end
    endcase

    duty_d = duty_ramp;
    if (state_d == ST_STALL) begin
      duty_d   = '0;
      target_d = '0;
    end

    stall_cnt_d = '0;
    if (state_d == state_q && state_q == ST_HOLD && duty_q != '0 && !tach_edge)
      stall_cnt_d = (stall_cnt_q == STALL_LIM) ? stall_cnt_q : stall_cnt_q + 1'b1;
  end

  // Active duty only changes at the period boundary so no pulse is ever cut short.
  assign pwm_kill   = (state_q == ST_STALL) || (state_d == ST_STALL);
  assign pwm_cnt_d  = (pwm_cnt_q == CNT_MAX) ? '0 : pwm_cnt_q + 1'b1;
  assign duty_act_d = pwm_kill ? '0 : ((pwm_cnt_q == '0) ? duty_q : duty_act_q);
  assign pwm_d      = !pwm_kill && (pwm_cnt_q < duty_act_d);

  // NOTE: only control/datapath flops here, no memories, so all take the async reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      duty_q      <= '0;
      div_q       <= '0;
      stall_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      duty_act_q  <= '0;
      pwm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      duty_q      <= duty_d;
      div_q       <= div_d;
      stall_cnt_q <= stall_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      duty_act_q  <= duty_act_d;
      pwm_q       <= pwm_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign duty        = duty_q;
  assign ramp_busy   = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
  assign stall_fault = (state_q == ST_STALL);

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Directed bench for fan_pwm_driver with fast ramp (div 4) and short stall timeout (64).
module tb_fan_pwm_driver;
  import fan_ctrl_defs::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] fan_speed = 2'd0;
  logic       speed_set = 1'b0;
  logic       fault_clear = 1'b0;
  logic       tach_run = 1'b0;
  logic       tach_tog = 1'b0;
  logic       tach_lvl = 1'b0;
  wire        tach_in = tach_run ? tach_tog : tach_lvl;
  logic       pwm_out, ramp_busy, stall_fault;
  logic [7:0] duty;

  int total = 0;
  int bad   = 0;

  fan_pwm_driver #(
    .PWM_BITS(8), .RAMP_DIV(4), .RAMP_STEP(5), .DUTY_LOW(85),
    .DUTY_MED(170), .DUTY_HIGH(255), .STALL_TIMEOUT(64)
  ) dut (
    .clk(clk), .reset_n(reset_n), .fan_speed(fan_speed), .speed_set(speed_set),
    .tach_in(tach_in), .fault_clear(fault_clear), .pwm_out(pwm_out), .duty(duty),
    .ramp_busy(ramp_busy), .stall_fault(stall_fault)
  );

  always #5 clk = ~clk;

  initial begin : tach_gen
    int tcnt = 0;
    forever begin
      @(negedge clk);
      if (tach_run) begin
        tcnt++;
        if (tcnt == 20) begin
          tach_tog = ~tach_tog;
          tcnt = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic set_speed(input logic [1:0] s);
    @(negedge clk);
    fan_speed = s;
    speed_set = 1'b1;
    @(negedge clk);
    speed_set = 1'b0;
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_out) hi++;
    end
  endtask

  initial begin : stim
    int hi, gap, steps, n, d, maxd;
    logic [7:0] prev;

    // 1: reset values, then asynchronous reset mid-ramp
    repeat (3) @(negedge clk);
    check("rst_duty", duty, 0);
    check("rst_pwm", pwm_out, 0);
    check("rst_busy", ramp_busy, 0);
    check("rst_stall", stall_fault, 0);
    reset_n = 1'b1;
    set_speed(2'd2);
    for (int i = 0; i < 200 && duty != 8'd40; i++) @(negedge clk);
    check("t1_reach40", duty, 40);
    check("t1_state_up", dut.state_q, ST_RAMP_UP);
    #1 reset_n = 1'b0;
    #1;
    check("t1_async_duty", duty, 0);
    check("t1_async_pwm", pwm_out, 0);
    check("t1_async_state", dut.state_q, ST_IDLE);
    check("t1_async_busy", ramp_busy, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // 2: ramp to low speed, one step of 5 every 4 clocks
    tach_run = 1'b1;
    set_speed(2'd1);
    prev = duty; gap = 0; steps = 0;
    for (int i = 0; i < 300 && duty != 8'd85; i++) begin
      @(negedge clk);
      gap++;
      if (duty != prev) begin
        d = int'(duty) - int'(prev);
        check("t2_step", d, 5);
        if (steps > 0) check("t2_gap", gap, 4);
        check("t2_busy", ramp_busy, duty != 8'd85);
        steps++; gap = 0; prev = duty;
      end
    end
    check("t2_steps", steps, 17);
    check("t2_duty", duty, 85);
    repeat (260) @(negedge clk);
    count_high(255, hi);
    check("t2_pwm_high", hi, 85);
    check("t2_no_stall", stall_fault, 0);
    set_speed(2'd0);
    for (int i = 0; i < 300 && !(duty == 8'd0 && dut.state_q == ST_IDLE); i++) @(negedge clk);
    check("t2_back_idle", dut.state_q, ST_IDLE);

    // 3: retarget to off at duty 60 while ramping to 170
    set_speed(2'd2);
    for (int i = 0; i < 200 && duty != 8'd60; i++) @(negedge clk);
    check("t3_reach60", duty, 60);
    check("t3_state_up", dut.state_q, ST_RAMP_UP);
    fan_speed = 2'd0;
    speed_set = 1'b1;
    @(negedge clk);
    speed_set = 1'b0;
    prev = duty; steps = 0; maxd = int'(duty);
    for (int i = 0; i < 200 && !(duty == 8'd0 && dut.state_q == ST_IDLE); i++) begin
      @(negedge clk);
      if (int'(duty) > maxd) maxd = int'(duty);
      if (duty != prev) begin
        d = int'(prev) - int'(duty);
        check("t3_step", d, 5);
        if (steps == 0) check("t3_state_down", dut.state_q, ST_RAMP_DOWN);
        steps++; prev = duty;
      end
    end
    check("t3_max", maxd, 60);
    check("t3_steps", steps, 12);
    check("t3_idle", dut.state_q, ST_IDLE);
    check("t3_busy", ramp_busy, 0);

    // 4: full speed then down to medium
    set_speed(2'd3);
    for (int i = 0; i < 400 && !(duty == 8'd255 && !ramp_busy); i++) @(negedge clk);
    check("t4_duty255", duty, 255);
    check("t4_hold", dut.state_q, ST_HOLD);
    repeat (260) @(negedge clk);
    count_high(255, hi);
    check("t4_pwm_all_high", hi, 255);
    set_speed(2'd2);
    for (int i = 0; i < 400 && !(duty == 8'd170 && !ramp_busy); i++) @(negedge clk);
    check("t4_duty170", duty, 170);
    repeat (260) @(negedge clk);
    count_high(255, hi);
    check("t4_pwm_high", hi, 170);
    check("t4_no_stall", stall_fault, 0);

    // 5: stall with tach stuck low
    tach_run = 1'b0;
    tach_lvl = 1'b0;
    set_speed(2'd1);
    for (int i = 0; i < 400 && !(duty == 8'd85 && !ramp_busy); i++) @(negedge clk);
    check("t5_hold85", duty, 85);
    n = 0;
    for (int i = 0; i < 200 && !stall_fault; i++) begin
      @(negedge clk);
      n++;
    end
    check("t5_stall_latency", n, 65);
    check("t5_stall", stall_fault, 1);
    check("t5_pwm_off", pwm_out, 0);
    check("t5_duty0", duty, 0);
    set_speed(2'd3);
    repeat (8) @(negedge clk);
    check("t5_ignore_set_duty", duty, 0);
    check("t5_ignore_set_state", dut.state_q, ST_STALL);
    fault_clear = 1'b1;
    fan_speed = 2'd2;
    speed_set = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    speed_set = 1'b0;
    check("t5_cleared", stall_fault, 0);
    check("t5_idle", dut.state_q, ST_IDLE);
    check("t5_target0", dut.target_q, 0);
    repeat (10) @(negedge clk);
    check("t5_stay_idle", dut.state_q, ST_IDLE);
    check("t5_stay_duty0", duty, 0);

    // 6: tach edge lands exactly on the timeout cycle
    set_speed(2'd1);
    for (int i = 0; i < 400 && !(duty == 8'd85 && !ramp_busy); i++) @(negedge clk);
    check("t6_hold85", duty, 85);
    for (int i = 0; i < 100 && dut.stall_cnt_q != 62; i++) @(negedge clk);
    check("t6_cnt62", dut.stall_cnt_q, 62);
    tach_lvl = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_cnt64", dut.stall_cnt_q, 64);
    check("t6_edge", dut.tach_edge, 1);
    @(negedge clk);
    check("t6_cnt_restart", dut.stall_cnt_q, 0);
    check("t6_no_stall", stall_fault, 0);
    check("t6_still_hold", dut.state_q, ST_HOLD);
    @(negedge clk);
    check("t6_cnt_counting", dut.stall_cnt_q, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
